// File: rtl/upsample_engine.sv
// 2x nearest-neighbour upsampler: each input row is streamed out twice, and each pixel is
// emitted twice per output row. The second output row of each pair is replayed from a line buffer.
module upsample_engine #(
    parameter int IN_DIM  = 14,
    parameter int OUT_DIM = 2 * IN_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic signed [7:0] pixel_in,
    output logic              in_ready,
    output logic              valid_out,
    output logic signed [7:0] pixel_out,
    input  logic              out_ready,
    output logic              all_done
);

    localparam int CW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int TOTAL = OUT_DIM * OUT_DIM;
    localparam int BW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] LAST_IDX  = CW'(IN_DIM - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(TOTAL - 1);

    typedef enum logic [1:0] {
        EVEN,
        ODD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              phase;
    logic [CW-1:0]     col;
    logic [CW-1:0]     row;
    logic [BW-1:0]     beat_cnt;
    logic signed [7:0] line_buf [IN_DIM];

    logic              xfer;
    logic              accept;
    logic              row_end;
    logic [CW-1:0]     col_inc;
    logic [CW-1:0]     wr_col;

    assign xfer    = valid_out && out_ready;
    assign accept  = valid_in && in_ready;
    assign row_end = xfer && phase && (col == LAST_IDX);
    assign col_inc = col + CW'(1);
    // While a beat is still showing, an accepted pixel belongs to the next column.
    assign wr_col  = valid_out ? col_inc : col;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned
    // and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            EVEN: begin
                // Last column of the row hands over to the replay, so no new pixel is taken then.
                in_ready = !valid_out || (phase && out_ready && (col != LAST_IDX));
                if (row_end) state_next = ODD;
            end
            ODD: begin
                if (row_end) state_next = (row == LAST_IDX) ? DONE : EVEN;
            end
            DONE:    state_next = DONE;
            default: state_next = EVEN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= EVEN;
        else     state <= state_next;
    end

    // NOTE: the line buffer is deliberately not reset; each entry is written in EVEN before ODD reads it.
    always_ff @(posedge clk) begin
        if (accept) line_buf[wr_col] <= pixel_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= 1'b0;
            col       <= '0;
            row       <= '0;
            beat_cnt  <= '0;
            valid_out <= 1'b0;
            pixel_out <= '0;
            all_done  <= 1'b0;
        end else begin
            if (xfer) begin
                beat_cnt <= beat_cnt + BW'(1);
                if (beat_cnt == LAST_BEAT) all_done <= 1'b1;
            end

            case (state)
                EVEN: begin
                    if (xfer && !phase) begin
                        phase <= 1'b1;
                    end else if (xfer) begin
                        phase <= 1'b0;
                        if (row_end) begin
                            col       <= '0;
                            pixel_out <= line_buf[0];
                            valid_out <= 1'b1;
                        end else begin
                            col <= col_inc;
                            if (accept) pixel_out <= pixel_in;
                            else        valid_out <= 1'b0;
                        end
                    end else if (accept) begin
                        pixel_out <= pixel_in;
                        valid_out <= 1'b1;
                        phase     <= 1'b0;
                    end
                end
                ODD: begin
                    if (xfer && !phase) begin
                        phase <= 1'b1;
                    end else if (xfer) begin
                        phase <= 1'b0;
                        if (col == LAST_IDX) begin
                            col       <= '0;
                            valid_out <= 1'b0;
                            if (row != LAST_IDX) row <= row + CW'(1);
                        end else begin
                            col       <= col_inc;
                            pixel_out <= line_buf[col_inc];
                        end
                    end
                end
                default: valid_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_upsample_engine.sv
// Directed bench for upsample_engine: a 2x2 instance for the detailed scenarios and a
// default 14x14 instance streamed with fixed valid/ready gap patterns.
module tb_upsample_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic              s_rst = 1'b1, s_valid_in = 1'b0, s_out_ready = 1'b1;
    logic              s_in_ready, s_valid_out, s_all_done;
    logic signed [7:0] s_pixel_in = '0, s_pixel_out;

    logic              l_rst = 1'b1, l_valid_in = 1'b0, l_out_ready = 1'b1;
    logic              l_in_ready, l_valid_out, l_all_done;
    logic signed [7:0] l_pixel_in = '0, l_pixel_out;

    upsample_engine #(.IN_DIM(2)) dut_s (
        .clk(clk), .rst(s_rst), .valid_in(s_valid_in), .pixel_in(s_pixel_in),
        .in_ready(s_in_ready), .valid_out(s_valid_out), .pixel_out(s_pixel_out),
        .out_ready(s_out_ready), .all_done(s_all_done)
    );

    upsample_engine dut_l (
        .clk(clk), .rst(l_rst), .valid_in(l_valid_in), .pixel_in(l_pixel_in),
        .in_ready(l_in_ready), .valid_out(l_valid_out), .pixel_out(l_pixel_out),
        .out_ready(l_out_ready), .all_done(l_all_done)
    );

    logic signed [7:0] in_q[$];
    logic signed [7:0] out_q[$];
    logic signed [7:0] lin[196];
    int extra_acc, stall_viol, odd_viol, last_cycle, done_cycle;
    bit timed_out;

    task automatic reset_s();
        s_valid_in  = 1'b0;
        s_out_ready = 1'b1;
        @(posedge clk); #1 s_rst = 1'b1;
        @(posedge clk); #1 s_rst = 1'b0;
    endtask

    // Streams in_q into the small instance with valid_in held high, optionally stalling
    // out_ready for stall_len cycles once stall_at beats have been taken, and stopping
    // early when stop_at beats have been taken.
    task automatic stream_s(input int stall_at, input int stall_len, input int stop_at, input int budget);
        int ip = 0;
        int stall_cnt = 0;
        logic signed [7:0] prev = '0;
        out_q.delete();
        extra_acc = 0; stall_viol = 0; odd_viol = 0;
        last_cycle = -1; done_cycle = -1; timed_out = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk); #1;
            s_out_ready = !(out_q.size() == stall_at && stall_cnt < stall_len);
            s_valid_in  = 1'b1;
            s_pixel_in  = (ip < in_q.size()) ? in_q[ip] : 8'sh55;
            #1;
            if (stop_at >= 0 && out_q.size() == stop_at) begin
                timed_out = 1'b0;
                break;
            end
            if (s_valid_in && s_in_ready) begin
                if (ip >= in_q.size()) extra_acc++;
                ip++;
            end
            if (!s_out_ready) begin
                if (!s_valid_out || s_in_ready || (stall_cnt > 0 && s_pixel_out !== prev)) stall_viol++;
                prev = s_pixel_out;
                stall_cnt++;
            end else if (s_valid_out) begin
                if (((out_q.size() / 4) % 2 == 1) && s_in_ready) odd_viol++;
                out_q.push_back(s_pixel_out);
                if (out_q.size() == 16) last_cycle = cyc;
            end
            if (s_all_done && done_cycle < 0) done_cycle = cyc;
            if (done_cycle >= 0 && cyc >= done_cycle + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        s_valid_in  = 1'b0;
        s_out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_s();
        n_checks++;
        if (s_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid_out: got %b expected 0", s_valid_out); end
        n_checks++;
        if (s_pixel_out !== 8'sd0) begin n_fail++; $display("FAIL reset pixel_out: got %0d expected 0", s_pixel_out); end
        n_checks++;
        if (s_all_done !== 1'b0) begin n_fail++; $display("FAIL reset all_done: got %b expected 0", s_all_done); end
        n_checks++;
        if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", s_in_ready); end
    endtask

    task automatic test_basic();
        int exp_b[16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
        reset_s();
        in_q = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        stream_s(-1, 0, -1, 200);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL basic timeout: all_done never rose within budget"); end
        n_checks++;
        if (out_q.size() != 16) begin n_fail++; $display("FAIL basic beat count: got %0d expected 16", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== 8'(exp_b[i])) begin
                n_fail++; $display("FAIL basic beat %0d: got %0d expected %0d", i, out_q[i], exp_b[i]);
            end
        end
        n_checks++;
        if (done_cycle != last_cycle + 1) begin
            n_fail++; $display("FAIL basic all_done timing: rose at cycle %0d expected %0d", done_cycle, last_cycle + 1);
        end
        n_checks++;
        if (extra_acc != 0) begin n_fail++; $display("FAIL basic extra accepts: got %0d expected 0", extra_acc); end
    endtask

    task automatic test_signed();
        int exp_b[16] = '{-128, -128, 127, 127, -128, -128, 127, 127, 5, 5, -6, -6, 5, 5, -6, -6};
        reset_s();
        in_q = '{8'sh80, 8'sh7f, 8'sd5, -8'sd6};
        stream_s(-1, 0, -1, 200);
        n_checks++;
        if (out_q.size() != 16) begin n_fail++; $display("FAIL signed beat count: got %0d expected 16", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== 8'(exp_b[i])) begin
                n_fail++; $display("FAIL signed beat %0d: got %0d expected %0d", i, out_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_stall();
        int exp_b[16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};
        reset_s();
        in_q = '{8'sd10, 8'sd20, 8'sd30, 8'sd40};
        stream_s(1, 5, -1, 200);
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL stall hold: %0d unstable or ready cycles, expected 0", stall_viol); end
        n_checks++;
        if (out_q.size() != 16) begin n_fail++; $display("FAIL stall beat count: got %0d expected 16", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== 8'(exp_b[i])) begin
                n_fail++; $display("FAIL stall beat %0d: got %0d expected %0d", i, out_q[i], exp_b[i]);
            end
        end
        n_checks++;
        if (extra_acc != 0) begin n_fail++; $display("FAIL stall extra accepts: got %0d expected 0", extra_acc); end
    endtask

    task automatic test_odd_valid();
        int exp_b[16] = '{-1, -1, -2, -2, -1, -1, -2, -2, -3, -3, -4, -4, -3, -3, -4, -4};
        reset_s();
        in_q = '{-8'sd1, -8'sd2, -8'sd3, -8'sd4};
        stream_s(5, 3, -1, 200);
        n_checks++;
        if (odd_viol != 0) begin n_fail++; $display("FAIL odd in_ready: high on %0d ODD beats, expected 0", odd_viol); end
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL odd stall hold: %0d bad cycles, expected 0", stall_viol); end
        n_checks++;
        if (extra_acc != 0) begin n_fail++; $display("FAIL odd extra accepts: got %0d expected 0", extra_acc); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== 8'(exp_b[i])) begin
                n_fail++; $display("FAIL odd beat %0d: got %0d expected %0d", i, out_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp_b[16] = '{9, 9, 8, 8, 9, 9, 8, 8, 7, 7, 6, 6, 7, 7, 6, 6};
        reset_s();
        in_q = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        stream_s(-1, 0, 13, 200);
        n_checks++;
        if (timed_out || done_cycle >= 0) begin
            n_fail++; $display("FAIL midreset abort point: timed_out %0d all_done cycle %0d expected 0 and -1", timed_out, done_cycle);
        end
        reset_s();
        n_checks++;
        if (s_valid_out !== 1'b0 || s_all_done !== 1'b0 || s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset outputs: valid_out %b all_done %b in_ready %b expected 0 0 1", s_valid_out, s_all_done, s_in_ready);
        end
        in_q = '{8'sd9, 8'sd8, 8'sd7, 8'sd6};
        stream_s(-1, 0, -1, 200);
        n_checks++;
        if (out_q.size() != 16) begin n_fail++; $display("FAIL midreset beat count: got %0d expected 16", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== 8'(exp_b[i])) begin
                n_fail++; $display("FAIL midreset beat %0d: got %0d expected %0d", i, out_q[i], exp_b[i]);
            end
        end
        n_checks++;
        if (done_cycle != last_cycle + 1) begin
            n_fail++; $display("FAIL midreset all_done timing: rose at cycle %0d expected %0d", done_cycle, last_cycle + 1);
        end
    endtask

    task automatic test_full_map_gaps();
        int ip = 0, nb = 0, extra = 0, last = -1, done = -1;
        for (int i = 0; i < 196; i++) lin[i] = 8'(i * 37 - 100);
        l_valid_in = 1'b0; l_out_ready = 1'b1;
        @(posedge clk); #1 l_rst = 1'b1;
        @(posedge clk); #1 l_rst = 1'b0;
        n_checks++;
        if (l_valid_out !== 1'b0 || l_all_done !== 1'b0 || l_in_ready !== 1'b1 || l_pixel_out !== 8'sd0) begin
            n_fail++; $display("FAIL big reset: valid_out %b all_done %b in_ready %b pixel_out %0d expected 0 0 1 0",
                               l_valid_out, l_all_done, l_in_ready, l_pixel_out);
        end
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(posedge clk); #1;
            l_valid_in  = (cyc % 5) != 3;
            l_out_ready = ((cyc % 7) != 4) && ((cyc % 11) != 6);
            l_pixel_in  = (ip < 196) ? lin[ip] : 8'sh00;
            #1;
            if (l_valid_in && l_in_ready) begin
                if (ip >= 196) extra++;
                ip++;
            end
            if (l_valid_out && l_out_ready) begin
                int r, c;
                r = nb / 28;
                c = nb % 28;
                n_checks++;
                if (l_pixel_out !== lin[(r / 2) * 14 + c / 2]) begin
                    n_fail++; $display("FAIL big beat %0d: got %0d expected %0d", nb, l_pixel_out, lin[(r / 2) * 14 + c / 2]);
                end
                nb++;
                if (nb == 784) last = cyc;
            end
            if (l_all_done && done < 0) done = cyc;
            if (done >= 0 && cyc >= done + 3) break;
        end
        n_checks++;
        if (nb != 784) begin n_fail++; $display("FAIL big beat count: got %0d expected 784", nb); end
        n_checks++;
        if (done != last + 1) begin n_fail++; $display("FAIL big all_done timing: rose at cycle %0d expected %0d", done, last + 1); end
        n_checks++;
        if (extra != 0) begin n_fail++; $display("FAIL big extra accepts: got %0d expected 0", extra); end
        l_valid_in = 1'b1; l_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (l_in_ready !== 1'b0 || l_valid_out !== 1'b0 || l_all_done !== 1'b1) begin
            n_fail++; $display("FAIL big after done: in_ready %b valid_out %b all_done %b expected 0 0 1",
                               l_in_ready, l_valid_out, l_all_done);
        end
        l_valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_stall();
        test_odd_valid();
        test_reset_mid();
        test_full_map_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
